// File: rtl/alu_muldiv_ctl.sv
// EX-stage HI/LO unit: decodes MULT/MULTU/DIV/DIVU/MTHI/MTLO/MFHI/MFLO and
// runs an iterative 1-bit/cycle multiplier and restoring divider.
// Ports: i_clk, i_rst_n (async, active-low), i_valid, i_alu_op, i_opcode,
// i_funct, i_rs, i_rt, i_flush in; o_busy, o_done, o_hi, o_lo, o_mf_data out.
// Optional macro MULACC_EN adds SPECIAL2 MADD/MADDU/MSUB/MSUBU.
module alu_muldiv_ctl #(
  parameter int NB_DATA      = 32,
  parameter int BITS_FUNCT   = 6,
  parameter int BITS_ALU_CTL = 2,
  parameter int NB_CNT       = $clog2(NB_DATA) + 1
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic                    i_valid,
  input  logic [BITS_ALU_CTL-1:0] i_alu_op,
  input  logic [BITS_FUNCT-1:0]   i_opcode,
  input  logic [BITS_FUNCT-1:0]   i_funct,
  input  logic [NB_DATA-1:0]      i_rs,
  input  logic [NB_DATA-1:0]      i_rt,
  input  logic                    i_flush,
  output logic                    o_busy,
  output logic                    o_done,
  output logic [NB_DATA-1:0]      o_hi,
  output logic [NB_DATA-1:0]      o_lo,
  output logic [NB_DATA-1:0]      o_mf_data
);

  localparam int N = NB_DATA;
  localparam logic [BITS_FUNCT-1:0] F_MFHI  = BITS_FUNCT'(6'b010000);
  localparam logic [BITS_FUNCT-1:0] F_MTHI  = BITS_FUNCT'(6'b010001);
  localparam logic [BITS_FUNCT-1:0] F_MFLO  = BITS_FUNCT'(6'b010010);
  localparam logic [BITS_FUNCT-1:0] F_MTLO  = BITS_FUNCT'(6'b010011);
  localparam logic [BITS_FUNCT-1:0] F_MULT  = BITS_FUNCT'(6'b011000);
  localparam logic [BITS_FUNCT-1:0] F_MULTU = BITS_FUNCT'(6'b011001);
  localparam logic [BITS_FUNCT-1:0] F_DIV   = BITS_FUNCT'(6'b011010);
  localparam logic [BITS_FUNCT-1:0] F_DIVU  = BITS_FUNCT'(6'b011011);
  localparam logic [BITS_FUNCT-1:0] OP_SPEC = '0;
  localparam logic [BITS_ALU_CTL-1:0] ALU_R = BITS_ALU_CTL'(2'b10);
  localparam logic [NB_CNT-1:0] LAST = NB_CNT'(NB_DATA - 1);

  typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

  state_t              state;
  logic [NB_CNT-1:0]   cnt;
  logic [N-1:0]        a_reg, b_reg, hi, lo;
  logic [2*N-1:0]      pa;
  logic                neg_res, neg_rem, dz;
  logic                is_div, is_mac, is_sub, done;

  logic rtype, go, acc_r, acc_s2;
  logic do_mthi, do_mtlo, do_mul, do_div;
  logic do_mac, mac_sub;

  assign rtype = (i_alu_op == ALU_R) & (i_opcode == OP_SPEC);
  assign go    = i_valid & (state == IDLE) & ~i_flush;
  assign acc_r = go & rtype;
`ifdef MULACC_EN
  assign acc_s2 = go & (i_opcode == BITS_FUNCT'(6'b011100));
`else
  assign acc_s2 = 1'b0;
`endif

  always_comb begin
    do_mthi = 1'b0;
    do_mtlo = 1'b0;
    do_mul  = 1'b0;
    do_div  = 1'b0;
    do_mac  = 1'b0;
    mac_sub = 1'b0;
    if (acc_r) begin
      unique case (1'b1)
        i_funct == F_MTHI:  do_mthi = 1'b1;
        i_funct == F_MTLO:  do_mtlo = 1'b1;
        i_funct == F_MULT,
        i_funct == F_MULTU: do_mul  = 1'b1;
        i_funct == F_DIV,
        i_funct == F_DIVU:  do_div  = 1'b1;
        default: ;
      endcase
    end
`ifdef MULACC_EN
    if (acc_s2) begin
      unique case (1'b1)
        i_funct == BITS_FUNCT'(6'b000000),
        i_funct == BITS_FUNCT'(6'b000001): do_mac = 1'b1;
        i_funct == BITS_FUNCT'(6'b000100),
        i_funct == BITS_FUNCT'(6'b000101): begin
          do_mac  = 1'b1;
          mac_sub = 1'b1;
        end
        default: ;
      endcase
    end
`endif
  end

  // Signed variants all have funct[0] == 0 (MULT, DIV, MADD, MSUB).
  logic         sgn, a_neg, b_neg;
  logic [N-1:0] a_abs, b_abs;
  assign sgn   = ~i_funct[0];
  assign a_neg = sgn & i_rs[N-1];
  assign b_neg = sgn & i_rt[N-1];
  assign a_abs = a_neg ? -i_rs : i_rs;
  assign b_abs = b_neg ? -i_rt : i_rt;

  // Shift-add: low half holds the multiplier, consumed LSB first.
  logic [N:0]     msum;
  logic [2*N-1:0] mnext;
  assign msum  = {1'b0, pa[2*N-1:N]} + (pa[0] ? {1'b0, a_reg} : '0);
  assign mnext = {msum, pa[N-1:1]};

  // Restoring divide: {remainder, quotient} shifts left one bit per step.
  logic [N:0]     rsh, diff;
  logic [2*N-1:0] dnext;
  assign rsh   = {pa[2*N-1:N], pa[N-1]};
  assign diff  = rsh - {1'b0, b_reg};
  assign dnext = diff[N] ? {rsh[N-1:0], pa[N-2:0], 1'b0}
                         : {diff[N-1:0], pa[N-2:0], 1'b1};

  logic [2*N-1:0] prod, mac_res;
  logic [N-1:0]   quo, rem;
  assign prod = neg_res ? -pa : pa;
  assign quo  = pa[N-1:0];
  assign rem  = pa[2*N-1:N];
  assign mac_res = is_sub ? ({hi, lo} - prod) : ({hi, lo} + prod);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state   <= IDLE;
      cnt     <= '0;
      a_reg   <= '0;
      b_reg   <= '0;
      pa      <= '0;
      hi      <= '0;
      lo      <= '0;
      neg_res <= 1'b0;
      neg_rem <= 1'b0;
      dz      <= 1'b0;
      is_div  <= 1'b0;
      is_mac  <= 1'b0;
      is_sub  <= 1'b0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      if (i_flush) begin
        state <= IDLE;
      end else begin
        unique case (state)
          IDLE: begin
            if (do_mthi) hi <= i_rs;
            if (do_mtlo) lo <= i_rs;
            if (do_mul | do_div | do_mac) begin
              state   <= RUN;
              cnt     <= '0;
              a_reg   <= a_abs;
              b_reg   <= b_abs;
              pa      <= do_div ? {{N{1'b0}}, a_abs}
                                : {{N{1'b0}}, b_abs};
              neg_res <= a_neg ^ b_neg;
              neg_rem <= a_neg;
              dz      <= do_div & (i_rt == '0);
              is_div  <= do_div;
              is_mac  <= do_mac;
              is_sub  <= mac_sub;
            end
          end
          RUN: begin
            pa <= is_div ? dnext : mnext;
            if (cnt == LAST) state <= FIX;
            else             cnt   <= cnt + 1'b1;
          end
          FIX: begin
            state <= IDLE;
            done  <= 1'b1;
            if (is_div && dz) begin
              hi <= neg_rem ? -a_reg : a_reg;
              lo <= '1;
            end else if (is_div) begin
              hi <= neg_rem ? -rem : rem;
              lo <= neg_res ? -quo : quo;
            end else if (is_mac) begin
              {hi, lo} <= mac_res;
            end else begin
              {hi, lo} <= prod;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  assign o_busy = (state != IDLE);
  assign o_done = done;
  assign o_hi   = hi;
  assign o_lo   = lo;

  always_comb begin
    o_mf_data = '0;
    if (rtype && i_funct == F_MFHI) o_mf_data = hi;
    if (rtype && i_funct == F_MFLO) o_mf_data = lo;
  end

endmodule

// File: tb/tb_alu_muldiv_ctl.sv
// Scoreboard bench for alu_muldiv_ctl: random and directed HI/LO ops
// checked against an arithmetic reference model.
module tb_alu_muldiv_ctl;
  localparam int N = 32;
  localparam logic [5:0] MFHI = 6'b010000, MTHI = 6'b010001;
  localparam logic [5:0] MFLO = 6'b010010, MTLO = 6'b010011;
  localparam logic [5:0] MULT = 6'b011000, MULTU = 6'b011001;
  localparam logic [5:0] DIV = 6'b011010, DIVU = 6'b011011;
  localparam logic [5:0] SP2 = 6'b011100;

  logic clk = 1'b0, rst_n = 1'b0, valid = 1'b0, flush = 1'b0;
  logic [1:0]  alu_op = 2'b00;
  logic [5:0]  opcode = 6'h0, funct = 6'h0;
  logic [31:0] rs = '0, rt = '0;
  logic        busy, done;
  logic [31:0] hi, lo, mf;

  always #5 clk = ~clk;

  alu_muldiv_ctl dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_valid(valid),
    .i_alu_op(alu_op), .i_opcode(opcode), .i_funct(funct),
    .i_rs(rs), .i_rt(rt), .i_flush(flush),
    .o_busy(busy), .o_done(done), .o_hi(hi), .o_lo(lo),
    .o_mf_data(mf)
  );

  int n_chk = 0, n_fail = 0, n_done = 0;
  logic [63:0] exp_q[$];
  logic [31:0] m_hi = '0, m_lo = '0;

  task automatic check(string name, logic [63:0] act,
                       logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: every done pulse consumes one expected {HI,LO}.
  always @(posedge clk) begin
    #1;
    if (rst_n && done) begin
      n_done++;
      if (exp_q.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL spurious_done: got hilo %h%h expected none",
                 hi, lo);
      end else begin
        check("done_hilo", {hi, lo}, exp_q.pop_front());
      end
    end
  end

  function automatic logic [63:0] ref_op(logic [5:0] f, logic s2,
      logic [31:0] a, logic [31:0] b, logic [63:0] hl);
    longint sa, sb, ua, ub, q, r, p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = longint'({32'h0, a});
    ub = longint'({32'h0, b});
    if (s2) begin
      p = f[0] ? ua * ub : sa * sb;
      return f[2] ? hl - 64'(p) : hl + 64'(p);
    end
    if (f == MULT)  return 64'(sa * sb);
    if (f == MULTU) return 64'(ua * ub);
    if (b == 0) return {a, 32'hFFFF_FFFF};
    if (f == DIV) begin
      q = sa / sb;
      r = sa % sb;
    end else begin
      q = ua / ub;
      r = ua % ub;
    end
    return {r[31:0], q[31:0]};
  endfunction

  task automatic issue(logic [1:0] cls, logic [5:0] opc,
                       logic [5:0] fn, logic [31:0] a, logic [31:0] b);
    @(negedge clk);
    valid = 1'b1; alu_op = cls; opcode = opc;
    funct = fn; rs = a; rt = b;
    @(negedge clk);
    valid = 1'b0; funct = 6'h0; opcode = 6'h0;
  endtask

  task automatic wait_idle(string name, int exp_n);
    int n = 0;
    while (busy && n < 100) begin
      n++;
      @(negedge clk);
    end
    check({name, "_busy_cycles"}, 64'(n), 64'(exp_n));
  endtask

  task automatic do_op(string name, logic [5:0] opc, logic [5:0] fn,
                       logic [31:0] a, logic [31:0] b);
    logic [63:0] e;
    e = ref_op(fn, opc == SP2, a, b, {m_hi, m_lo});
    exp_q.push_back(e);
    {m_hi, m_lo} = e;
    issue(opc == SP2 ? 2'b00 : 2'b10, opc, fn, a, b);
    wait_idle(name, N + 1);
    @(negedge clk);
    check({name, "_hilo"}, {hi, lo}, {m_hi, m_lo});
  endtask

  task automatic mt(string name, logic [5:0] fn, logic [31:0] a);
    issue(2'b10, 6'h0, fn, a, '0);
    if (fn == MTHI) m_hi = a;
    else            m_lo = a;
    check({name, "_busy"}, 64'(busy), 64'(0));
    check({name, "_hilo"}, {hi, lo}, {m_hi, m_lo});
  endtask

  task automatic mf_chk(string name);
    @(negedge clk);
    valid = 1'b1; alu_op = 2'b10; opcode = 6'h0; funct = MFHI;
    #1 check({name, "_mfhi"}, 64'(mf), 64'(m_hi));
    funct = MFLO;
    #1 check({name, "_mflo"}, 64'(mf), 64'(m_lo));
    valid = 1'b0; funct = 6'h0;
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0: return 32'h0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'(32'($urandom_range(0, 20)));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    int n0;
    logic [5:0] ops [6];
    ops = '{MULT, MULTU, DIV, DIVU, MTHI, MTLO};
    repeat (3) @(negedge clk);
    check("rst_hilo", {hi, lo}, 64'h0);
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_done", 64'(done), 64'(0));
    rst_n = 1'b1;

    do_op("mult_m1x2", SP2 ^ SP2, MULT, 32'hFFFF_FFFF, 32'h2);
    check("mult_m1x2_const", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFE);
    do_op("divu_100_7", 6'h0, DIVU, 32'd100, 32'd7);
    check("divu_const", {hi, lo}, {32'd2, 32'd14});
    do_op("div_m7_2", 6'h0, DIV, 32'hFFFF_FFF9, 32'd2);
    check("div_m7_const", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFD);
    do_op("div_min_m1", 6'h0, DIV, 32'h8000_0000, 32'hFFFF_FFFF);
    check("div_min_const", {hi, lo}, {32'h0, 32'h8000_0000});
    do_op("divu_dz", 6'h0, DIVU, 32'h1234, 32'h0);
    check("divu_dz_const", {hi, lo}, {32'h1234, 32'hFFFF_FFFF});
    do_op("div_dz_neg", 6'h0, DIV, 32'hFFFF_FFFB, 32'h0);

    mt("mthi", MTHI, 32'hCAFE_F00D);
    mf_chk("mf_after_mthi");
    check("mthi_const", 64'(hi), 64'h0000_0000_CAFE_F00D);

    // MTLO while busy must be ignored.
    begin
      logic [63:0] e;
      e = ref_op(MULT, 1'b0, 32'd3, 32'd7, {m_hi, m_lo});
      exp_q.push_back(e);
      {m_hi, m_lo} = e;
      issue(2'b10, 6'h0, MULT, 32'd3, 32'd7);
      valid = 1'b1; alu_op = 2'b10; funct = MTLO; rs = 32'hDEAD;
      repeat (2) @(negedge clk);
      valid = 1'b0; funct = 6'h0;
      wait_idle("mtlo_busy", N - 1);
      @(negedge clk);
      check("mtlo_busy_hilo", {hi, lo}, {m_hi, m_lo});
    end

    issue(2'b00, 6'h0, MULT, 32'd9, 32'd9);
    check("non_rtype_busy", 64'(busy), 64'(0));
    check("non_rtype_hilo", {hi, lo}, {m_hi, m_lo});

    @(negedge clk);
    valid = 1'b1; alu_op = 2'b10; funct = MULT; flush = 1'b1;
    rs = 32'd2; rt = 32'd2;
    @(negedge clk);
    valid = 1'b0; flush = 1'b0; funct = 6'h0;
    check("flush_accept_busy", 64'(busy), 64'(0));

    n0 = n_done;
    issue(2'b10, 6'h0, MULTU, 32'd5, 32'd6);
    repeat (9) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    check("flush_busy", 64'(busy), 64'(0));
    repeat (40) @(negedge clk);
    check("flush_hilo", {hi, lo}, {m_hi, m_lo});
    check("flush_no_done", 64'(n_done), 64'(n0));

    issue(2'b10, 6'h0, MULTU, 32'd5, 32'd6);
    repeat (9) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("arst_hilo", {hi, lo}, 64'h0);
    check("arst_busy", 64'(busy), 64'(0));
    check("arst_done", 64'(done), 64'(0));
    m_hi = '0; m_lo = '0;
    @(negedge clk);
    rst_n = 1'b1;

`ifdef MULACC_EN
    mt("mac_hi0", MTHI, 32'h0);
    mt("mac_lo10", MTLO, 32'd10);
    do_op("madd", SP2, 6'b000000, 32'd3, 32'd4);
    check("madd_const", {hi, lo}, 64'd22);
    do_op("msub", SP2, 6'b000100, 32'd5, 32'd5);
    check("msub_const", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFD);
    do_op("maddu", SP2, 6'b000001, 32'hFFFF_FFFF, 32'd3);
    do_op("msubu", SP2, 6'b000101, 32'h8000_0000, 32'd7);
`else
    mt("sp2_pre", MTLO, 32'd10);
    issue(2'b10, SP2, 6'b000000, 32'd3, 32'd4);
    check("sp2_ignored_busy", 64'(busy), 64'(0));
    check("sp2_ignored_hilo", {hi, lo}, {m_hi, m_lo});
`endif

    for (int i = 0; i < 24; i++) begin
      logic [5:0] f;
      f = ops[$urandom_range(0, 5)];
      if (f == MTHI || f == MTLO) mt("rnd_mt", f, pick());
      else do_op("rnd", 6'h0, f, pick(), pick());
      mf_chk("rnd_mf");
    end

    repeat (5) @(negedge clk);
    check("queue_empty", 64'(exp_q.size()), 64'(0));
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end
endmodule
